// File: rtl/logic_unit_pkg.sv
// Purpose: shared op-code constants for the pipelined logic unit.
// Latency: n/a (constants only).
// Backpressure: n/a.
package logic_unit_pkg;

    localparam int LU_OP_W = 3;

    localparam logic [LU_OP_W-1:0] LU_AND  = 3'd0;  // x & y
    localparam logic [LU_OP_W-1:0] LU_OR   = 3'd1;  // x | y
    localparam logic [LU_OP_W-1:0] LU_XOR  = 3'd2;  // x ^ y
    localparam logic [LU_OP_W-1:0] LU_NOR  = 3'd3;  // ~(x | y)
    localparam logic [LU_OP_W-1:0] LU_ANDN = 3'd4;  // x & ~y
    localparam logic [LU_OP_W-1:0] LU_ORN  = 3'd5;  // x | ~y
    localparam logic [LU_OP_W-1:0] LU_XNOR = 3'd6;  // ~(x ^ y)
    localparam logic [LU_OP_W-1:0] LU_PASS = 3'd7;  // x

endpackage

// File: rtl/lu_pipe_stage.sv
// Purpose: one valid/data register slice of the logic-unit pipeline.
// Latency: 1 cycle.
// Backpressure: the parent computes load (empty or advancing); the slice holds while load is low.
// Ports: clk, rst_n (async active-low), flush (clears valid), load (take upstream this edge),
//        up_valid/up_data (upstream slice or input), valid/data (registered contents).
module lu_pipe_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          load,
    input  logic          up_valid,
    input  logic [DW-1:0] up_data,
    output logic          valid,
    output logic [DW-1:0] data
);

    // When loading, the valid bit follows upstream, so an advancing slice with
    // nothing behind it becomes a bubble. Flush wins over any load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= up_valid;
        end
    end

    // Data only moves when something real arrives; stale data behind a cleared
    // valid bit is harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (load && up_valid) begin
            data <= up_data;
        end
    end

endmodule

// File: rtl/pipelined_logic_unit.sv
// Purpose: eight-op bitwise logic unit with tag and zero flag, STAGES register stages deep.
// Latency: STAGES cycles from input fire to out_valid; 1 op/cycle throughput.
// Backpressure: valid/ready; stages fill while out_ready is low, then in_ready drops (capacity STAGES).
// Ports: clk, rst_n (async active-low), flush (squash all in-flight ops),
//        in_valid/in_ready/in_op/in_x/in_y/in_tag (operand side),
//        out_valid/out_ready/out_result/out_zero/out_tag (result side).
// Option: define LOGIC_UNIT_PERF_CNT_EN to add perf_count, a saturating count of output fires.
module pipelined_logic_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LU_OP_W-1:0] in_op,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [WIDTH-1:0]   in_y,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic               out_zero,
    output logic [TAG_W-1:0]   out_tag
`ifdef LOGIC_UNIT_PERF_CNT_EN
    ,
    output logic [31:0]        perf_count
`endif
);

    localparam int DW = WIDTH + 1 + TAG_W;  // {result, zero, tag}

    logic [WIDTH-1:0] op_res;
    logic [STAGES:0]  vld;                  // index 0 is the input port
    logic [DW-1:0]    dat [0:STAGES];
    logic [STAGES:1]  ld;
    logic             zero_q;

    always_comb begin
        op_res = '0;
        case (in_op)
            LU_AND:  op_res = in_x & in_y;
            LU_OR:   op_res = in_x | in_y;
            LU_XOR:  op_res = in_x ^ in_y;
            LU_NOR:  op_res = ~(in_x | in_y);
            LU_ANDN: op_res = in_x & ~in_y;
            LU_ORN:  op_res = in_x | ~in_y;
            LU_XNOR: op_res = ~(in_x ^ in_y);
            LU_PASS: op_res = in_x;
            default: op_res = in_x;
        endcase
    end

    assign vld[0] = in_valid;
    assign dat[0] = {op_res, (op_res == '0), in_tag};

    // A stage may load when any stage from it to the output has a hole, or the
    // output is being taken. Walking from the output back gives the whole ready
    // chain in one pass with no comb feedback between stages.
    always_comb begin : p_load
        logic room;
        ld   = '0;
        room = out_ready;
        for (int i = STAGES; i >= 1; i--) begin
            room  = room || !vld[i];
            ld[i] = room;
        end
    end

    for (genvar g = 1; g <= STAGES; g++) begin : g_stage
        lu_pipe_stage #(
            .DW(DW)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush   (flush),
            .load    (ld[g]),
            .up_valid(vld[g-1]),
            .up_data (dat[g-1]),
            .valid   (vld[g]),
            .data    (dat[g])
        );
    end

    assign in_ready  = ld[1];
    assign out_valid = vld[STAGES];
    assign {out_result, zero_q, out_tag} = dat[STAGES];
    assign out_zero  = out_valid & zero_q;

`ifdef LOGIC_UNIT_PERF_CNT_EN
    // Counts consumer handshakes; flush does not clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_count <= '0;
        end else if (out_valid && out_ready && (perf_count != 32'hFFFF_FFFF)) begin
            perf_count <= perf_count + 32'd1;
        end
    end
`endif

endmodule
